// File: rtl/clint_pkg.sv
// Shared definitions for the core-local interruptor and its MMIO requesters.
// Holds the register offsets, the request FSM encoding and bus field widths.
// Also provides the byte-lane merge used by every writable register.
package clint_pkg;

  // MMIO request/response field widths, shared with the LSU-side MMIO arbiter.
  localparam int unsigned CLINT_ADDR_W = 64;
  localparam int unsigned CLINT_DATA_W = 64;
  localparam int unsigned CLINT_STRB_W = CLINT_DATA_W / 8;
  localparam int unsigned CLINT_OFF_W  = 16;

  // Register offsets inside the 64 KiB region; lanes are aligned to 64-bit words.
  localparam logic [CLINT_OFF_W-1:0] CLINT_MSIP_OFF     = 16'h0000;
  localparam logic [CLINT_OFF_W-1:0] CLINT_MTIMECMP_OFF = 16'h4000;
  localparam logic [CLINT_OFF_W-1:0] CLINT_MTIME_OFF    = 16'hBFF8;

  // Request handshake: accept in IDLE, present the response for one cycle in RESP.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } clint_state_e;

  // Replace each byte of old_v whose strobe bit is set with the byte from new_v.
  function automatic logic [CLINT_DATA_W-1:0] clint_merge(
    input logic [CLINT_DATA_W-1:0] old_v,
    input logic [CLINT_DATA_W-1:0] new_v,
    input logic [CLINT_STRB_W-1:0] strb
  );
    logic [CLINT_DATA_W-1:0] res;
    res = old_v;
    for (int b = 0; b < int'(CLINT_STRB_W); b++) begin
      if (strb[b]) begin
        res[8*b +: 8] = new_v[8*b +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/clint_timer.sv
// Machine timer: prescaler, free-running mtime, mtimecmp and the pending compare.
// Writes land on the edge they are presented; o_stop follows the registers combinationally.
// No backpressure: write enables are single-cycle strobes from the request FSM.
module clint_timer
  import clint_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1,
  parameter int unsigned TICK_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_mtime_we,
  input  logic                    i_mtimecmp_we,
  input  logic [CLINT_DATA_W-1:0] i_wdata,
  input  logic [CLINT_STRB_W-1:0] i_wstrb,
  output logic [CLINT_DATA_W-1:0] o_mtime,
  output logic [CLINT_DATA_W-1:0] o_mtimecmp,
  output logic                    o_stop
);

  localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(TICK_DIV - 1);

  logic [TICK_W-1:0]       r_tick_cnt;
  logic [CLINT_DATA_W-1:0] r_mtime;
  logic [CLINT_DATA_W-1:0] r_mtimecmp;

  logic                    w_tick;
  logic [CLINT_DATA_W-1:0] w_mtime_inc;
  logic [CLINT_DATA_W-1:0] w_mtime_nxt;
  logic [CLINT_DATA_W-1:0] w_mtimecmp_nxt;

  assign w_tick      = (r_tick_cnt == TICK_MAX);
  // Full 64-bit increment first, so a carry out of unwritten low bytes still
  // reaches the unwritten high bytes; wraps silently at 2^64-1.
  assign w_mtime_inc = r_mtime + {{(CLINT_DATA_W-1){1'b0}}, w_tick};

  // Bus write wins over the increment on written bytes only.
  always_comb begin
    w_mtime_nxt    = w_mtime_inc;
    w_mtimecmp_nxt = r_mtimecmp;
    if (i_mtime_we) begin
      w_mtime_nxt = clint_merge(w_mtime_inc, i_wdata, i_wstrb);
    end
    if (i_mtimecmp_we) begin
      w_mtimecmp_nxt = clint_merge(r_mtimecmp, i_wdata, i_wstrb);
    end
  end

  // Prescaler: counts 0..TICK_DIV-1 and is never disturbed by bus writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + TICK_W'(1);
    end
  end

  // Timer registers; mtimecmp resets to all-ones so nothing is pending out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mtime    <= '0;
      r_mtimecmp <= '1;
    end else begin
      r_mtime    <= w_mtime_nxt;
      r_mtimecmp <= w_mtimecmp_nxt;
    end
  end

  assign o_mtime    = r_mtime;
  assign o_mtimecmp = r_mtimecmp;
  // Level, unsigned compare; it clears only through a mtimecmp (or mtime) write.
  assign o_stop     = (r_mtime >= r_mtimecmp);

endmodule

// File: rtl/clint.sv
// Core-local interruptor: MMIO decode for msip, mtimecmp and mtime plus the request FSM.
// Latency: request accepted on the edge it is seen in IDLE, one-cycle response strobe next cycle.
// Backpressure: none; valid seen during the response cycle is ignored, so at most one request per 2 cycles.
module clint
  import clint_pkg::*;
#(
  parameter logic [63:0] BASE     = 64'h0000_0000_0200_0000,
  parameter int unsigned TICK_DIV = 1,
  parameter int unsigned TICK_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_clint_valid,
  input  logic                    i_clint_wen,
  input  logic [CLINT_ADDR_W-1:0] i_clint_addr,
  input  logic [CLINT_DATA_W-1:0] i_clint_wdata,
  input  logic [CLINT_STRB_W-1:0] i_clint_wstrb,
  output logic                    o_clint_ready,
  output logic [CLINT_DATA_W-1:0] o_clint_rdata,
  output logic                    o_clint_stop,
  output logic                    o_clint_msip
);

  clint_state_e            r_state;
  logic                    r_ready;
  logic [CLINT_DATA_W-1:0] r_rdata;
  logic                    r_msip;

  logic                    w_hit;
  logic [CLINT_OFF_W-1:0]  w_off;
  logic                    w_sel_msip;
  logic                    w_sel_mtimecmp;
  logic                    w_sel_mtime;
  logic                    w_accept;
  logic                    w_wr;
  logic [CLINT_DATA_W-1:0] w_rd_val;
  logic [CLINT_DATA_W-1:0] w_mtime;
  logic [CLINT_DATA_W-1:0] w_mtimecmp;
  logic                    w_stop;

  // Region hit on the upper address bits; register select needs an exact,
  // word-aligned offset, so 32-bit upper-half accesses fall through as misses.
  assign w_hit          = (i_clint_addr[CLINT_ADDR_W-1:CLINT_OFF_W] == BASE[CLINT_ADDR_W-1:CLINT_OFF_W]);
  assign w_off          = i_clint_addr[CLINT_OFF_W-1:0];
  assign w_sel_msip     = w_hit && (w_off == CLINT_MSIP_OFF);
  assign w_sel_mtimecmp = w_hit && (w_off == CLINT_MTIMECMP_OFF);
  assign w_sel_mtime    = w_hit && (w_off == CLINT_MTIME_OFF);

  assign w_accept = (r_state == ST_IDLE) && i_clint_valid;
  assign w_wr     = w_accept && i_clint_wen;

  clint_timer #(
    .TICK_DIV (TICK_DIV),
    .TICK_W   (TICK_W)
  ) u_timer (
    .clk           (clk),
    .rst           (rst),
    .i_mtime_we    (w_wr && w_sel_mtime),
    .i_mtimecmp_we (w_wr && w_sel_mtimecmp),
    .i_wdata       (i_clint_wdata),
    .i_wstrb       (i_clint_wstrb),
    .o_mtime       (w_mtime),
    .o_mtimecmp    (w_mtimecmp),
    .o_stop        (w_stop)
  );

  // Read mux over the pre-edge register values; unmapped offsets read as zero.
  always_comb begin
    w_rd_val = '0;
    if (w_sel_msip) begin
      w_rd_val = {{(CLINT_DATA_W-1){1'b0}}, r_msip};
    end else if (w_sel_mtimecmp) begin
      w_rd_val = w_mtimecmp;
    end else if (w_sel_mtime) begin
      w_rd_val = w_mtime;
    end
  end

  // Software-interrupt bit: only lane 0, bit 0 is implemented.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_msip <= 1'b0;
    end else if (w_wr && w_sel_msip && i_clint_wstrb[0]) begin
      r_msip <= i_clint_wdata[0];
    end
  end

  // Request FSM with registered response; reset drops any outstanding response.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ready <= 1'b0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_clint_valid) begin
            r_state <= ST_RESP;
            r_ready <= 1'b1;
            r_rdata <= i_clint_wen ? '0 : w_rd_val;
          end else begin
            r_ready <= 1'b0;
            r_rdata <= '0;
          end
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b0;
          r_rdata <= '0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b0;
          r_rdata <= '0;
        end
      endcase
    end
  end

  assign o_clint_ready = r_ready;
  assign o_clint_rdata = r_rdata;
  assign o_clint_stop  = w_stop;
  assign o_clint_msip  = r_msip;

endmodule
